// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and stage-1 record for the multiplier final adder
//
// Purpose : constants and the stage-1 pipeline record used by mult_final_adder.
// Ports   : none (package).
package mult_pkg;

  localparam int PROD_W = 8;
  localparam int NIB_W  = 4;
  localparam int CNT_W  = 16;

  // Stage-1 record: untouched high nibbles of both rows, low-half sum and its carry.
  typedef struct packed {
    logic [NIB_W-1:0] hi_s;
    logic [NIB_W-1:0] hi_c;
    logic [NIB_W-1:0] lo;
    logic             c4;
  } s1_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full-adder cell
//
// Purpose : one-bit sum and carry of three inputs.
// Ports   : i_a, i_b, i_cin -> o_sum, o_cout
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_sum  = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/nibble_adder.sv
// rtl/nibble_adder.sv - ripple-carry adder built from full-adder cells
//
// Purpose : W-bit ripple-carry add with carry in and carry out.
// Ports   : i_a, i_b [W-1:0], i_cin -> o_sum [W-1:0], o_cout
module nibble_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < W; g++) begin : g_bit
    full_adder u_fa (
      .i_a    (i_a[g]),
      .i_b    (i_b[g]),
      .i_cin  (w_carry[g]),
      .o_sum  (o_sum[g]),
      .o_cout (w_carry[g+1])
    );
  end

  assign o_cout = w_carry[W];

endmodule

// File: rtl/mult_final_adder.sv
// rtl/mult_final_adder.sv - two-stage carry-propagate adder for the compressor multiplier
//
// Purpose : adds the sum and carry rows from the compressor tree as two nibble halves
//           over two pipeline stages, with valid/ready handshakes on both sides.
// Ports   : clk, rst (async, active-high)
//           in_valid, in_ready, row_s, row_c          - row input stream
//           out_valid, out_ready, product, ovf        - product output stream
//           prod_count                                - saturating count of handed-off products
module mult_final_adder #(
  parameter int PROD_W = 8,
  parameter int NIB_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] row_s,
  input  logic [PROD_W-1:0] row_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              ovf,
  output logic [CNT_W-1:0]  prod_count
);

  import mult_pkg::*;

  s1_t               r_s1;
  logic              r_s1_valid;
  logic [PROD_W-1:0] r_product;
  logic              r_ovf;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_count;

  logic              w_s1_adv;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [NIB_W-1:0]  w_lo;
  logic              w_c4;
  logic [NIB_W-1:0]  w_hi;
  logic              w_c8;

  // s1 may move forward whenever the output register is empty or being drained.
  assign w_s1_adv   = r_s1_valid && (!r_out_valid || out_ready);
  // Depends only on state and out_ready, never on in_valid. Held low during reset.
  assign in_ready   = !rst && (!r_s1_valid || w_s1_adv);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Low half is added on the way into s1.
  nibble_adder #(.W(NIB_W)) u_lo_add (
    .i_a    (row_s[NIB_W-1:0]),
    .i_b    (row_c[NIB_W-1:0]),
    .i_cin  (1'b0),
    .o_sum  (w_lo),
    .o_cout (w_c4)
  );

  // High half is added out of s1, consuming the stored low-half carry.
  nibble_adder #(.W(NIB_W)) u_hi_add (
    .i_a    (r_s1.hi_s),
    .i_b    (r_s1.hi_c),
    .i_cin  (r_s1.c4),
    .o_sum  (w_hi),
    .o_cout (w_c8)
  );

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_s1.hi_s <= row_s[PROD_W-1:NIB_W];
        r_s1.hi_c <= row_c[PROD_W-1:NIB_W];
        r_s1.lo   <= w_lo;
        r_s1.c4   <= w_c4;
      end
      // A reload on the same edge as an advance keeps s1 full.
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Output register: loads on advance, otherwise empties on a transfer, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product   <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_product   <= {w_hi, r_s1.lo};
        r_ovf       <= w_c8;
        r_out_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Completed-product counter, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_out_xfer && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign product    = r_product;
  assign ovf        = r_ovf;
  assign prod_count = r_count;

endmodule

// File: tb/tb_mult_final_adder.sv
// tb/tb_mult_final_adder.sv - self-checking bench for mult_final_adder
module tb_mult_final_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  row_s = 8'h00;
  logic [7:0]  row_c = 8'h00;

  logic        in_ready, out_valid, ovf;
  logic [7:0]  product;
  logic [15:0] prod_count;
  logic        in_ready4, out_valid4, ovf4;
  logic [7:0]  product4;
  logic [3:0]  prod_count4;

  mult_final_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .row_s(row_s), .row_c(row_c), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .ovf(ovf), .prod_count(prod_count)
  );

  mult_final_adder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .row_s(row_s), .row_c(row_c), .out_valid(out_valid4), .out_ready(out_ready),
    .product(product4), .ovf(ovf4), .prod_count(prod_count4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] p; logic o; int age; } item_t;
  typedef struct { logic [7:0] s; logic [7:0] c; } stim_t;

  item_t mq[$];          // products accepted but not yet handed off, oldest first
  stim_t sq[$];          // rows waiting to be offered
  int    m_cnt  = 0;
  int    m_cnt4 = 0;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc = 0;
  int    present_cyc = 0;
  bit    rnd_gap = 1'b0;
  bit    rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a product may be handed off once it has spent one edge in the
  // pipe; at most two are in flight, and a third is taken only when one leaves.
  initial begin : model
    bit    ex_ir, ex_ov, xin, xout;
    item_t it;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete();
        m_cnt  = 0;
        m_cnt4 = 0;
      end else begin
        ex_ir = (mq.size() < 2) || out_ready;
        ex_ov = (mq.size() > 0) && (mq[0].age >= 1);
        xin   = in_valid && ex_ir;
        xout  = ex_ov && out_ready;
        if (xout) begin
          void'(mq.pop_front());
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        foreach (mq[i]) mq[i].age++;
        if (xin) begin
          {it.o, it.p} = {1'b0, row_s} + {1'b0, row_c};
          it.age = 0;
          mq.push_back(it);
        end
      end
    end
  end

  // Input driver: holds an offer until taken, random idle gaps when enabled.
  initial begin : drv
    bit acc;
    forever begin
      @(posedge clk);
      acc = in_valid && in_ready;
      #1;
      if (acc) void'(sq.pop_front());
      if (in_valid && !acc) begin
        // keep offering the same rows
      end else if (sq.size() > 0 && (!rnd_gap || $urandom_range(3) != 0)) begin
        in_valid    = 1'b1;
        row_s       = sq[0].s;
        row_c       = sq[0].c;
        present_cyc = cyc;
      end else begin
        in_valid = 1'b0;
        row_s    = 8'($urandom);
        row_c    = 8'($urandom);
      end
    end
  end

  initial begin : rdy
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(1));
    end
  end

  // Every-cycle comparison against the model.
  initial begin : cmp
    bit ex_ir, ex_ov;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_product", {24'd0, product}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        chk("rst_count", {16'd0, prod_count}, 0);
        chk("rst_count4", {28'd0, prod_count4}, 0);
      end else begin
        ex_ir = (mq.size() < 2) || out_ready;
        ex_ov = (mq.size() > 0) && (mq[0].age >= 1);
        chk("in_ready", {31'd0, in_ready}, {31'd0, ex_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ex_ov});
        chk("in_ready4", {31'd0, in_ready4}, {31'd0, ex_ir});
        chk("out_valid4", {31'd0, out_valid4}, {31'd0, ex_ov});
        if (ex_ov) begin
          chk("product", {24'd0, product}, {24'd0, mq[0].p});
          chk("ovf", {31'd0, ovf}, {31'd0, mq[0].o});
          chk("product4", {24'd0, product4}, {24'd0, mq[0].p});
        end
        chk("prod_count", {16'd0, prod_count}, m_cnt);
        chk("prod_count4", {28'd0, prod_count4}, m_cnt4);
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while ((sq.size() != 0 || mq.size() != 0 || in_valid) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cyc) chk("drain_timeout", 1, 0);
  endtask

  task automatic single(input logic [7:0] s, input logic [7:0] c, input logic [7:0] ep,
                        input logic eo, input int ecnt);
    stim_t st;
    bit    seen;
    seen = 1'b0;
    step();
    out_ready = 1'b1;
    st.s = s;
    st.c = c;
    sq.push_back(st);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      chk("single_timeout", 0, 1);
    end else begin
      chk("single_product", {24'd0, product}, {24'd0, ep});
      chk("single_ovf", {31'd0, ovf}, {31'd0, eo});
      chk("single_model", {23'd0, mq[0].o, mq[0].p}, {23'd0, eo, ep});
      chk("single_latency", cyc - present_cyc, 2);
      @(negedge clk);
      chk("single_count", {16'd0, prod_count}, ecnt);
    end
  endtask

  initial begin : wd
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    stim_t       st;
    logic [7:0]  exp_p[4];
    logic [7:0]  got_p[4];
    logic [7:0]  held;
    int          n, k, first, last, t0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 0);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_product", {24'd0, product}, 0);
    chk("reset_count", {16'd0, prod_count}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 1);

    // Directed single transfers
    single(8'h81, 8'h60, 8'hE1, 1'b0, 1);
    single(8'h0F, 8'h01, 8'h10, 1'b0, 2);
    single(8'hF0, 8'h20, 8'h10, 1'b1, 3);
    wait_idle(20);

    // Back-pressure: 4 rows offered with the consumer stalled
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st.s = 8'($urandom);
      st.c = 8'($urandom);
      exp_p[i] = st.s + st.c;
      sq.push_back(st);
    end
    k = 0;
    while (mq.size() < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_fill", mq.size(), 2);
    chk("bp_in_ready_low", {31'd0, in_ready}, 0);
    held = product;
    chk("bp_first_out", {24'd0, held}, {24'd0, exp_p[0]});
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_product", {24'd0, product}, {24'd0, held});
      chk("bp_hold_valid", {31'd0, out_valid}, 1);
    end
    step();
    out_ready = 1'b1;
    n = 0; first = -1; last = -1;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got_p[n] = product;
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    chk("bp_count_out", n, 4);
    for (int i = 0; i < 4; i++) chk("bp_order", {24'd0, got_p[i]}, {24'd0, exp_p[i]});
    chk("bp_rate", last - first, 3);
    wait_idle(20);

    // Asynchronous reset with two products in flight
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st.s = 8'($urandom);
      st.c = 8'($urandom);
      sq.push_back(st);
    end
    k = 0;
    while (mq.size() < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mr_fill", mq.size(), 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 0);
    chk("mr_product", {24'd0, product}, 0);
    chk("mr_count", {16'd0, prod_count}, 0);
    chk("mr_in_ready", {31'd0, in_ready}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    single(8'h12, 8'h34, 8'h46, 1'b0, 1);
    wait_idle(20);

    // Sixteen more transfers: 17 since reset
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      st.s = 8'($urandom);
      st.c = 8'($urandom);
      sq.push_back(st);
    end
    wait_idle(100);
    chk("sat_count4", {28'd0, prod_count4}, 32'hF);
    chk("sat_count16", {16'd0, prod_count}, 17);

    // Full-rate streaming
    step();
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      st.s = 8'($urandom);
      st.c = 8'($urandom);
      sq.push_back(st);
    end
    wait_idle(200);
    chk("stream_rate", (cyc - t0 <= 44) ? 1 : 0, 1);

    // Randomized traffic
    step();
    rnd_gap = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      st.s = 8'($urandom);
      st.c = 8'($urandom);
      sq.push_back(st);
    end
    wait_idle(4000);
    rnd_ready = 1'b0;
    rnd_gap = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
